// File: rtl/udp_stream_arbiter.sv
// Round-robin AXI-Stream arbiter merging PORT_NUMBER UDP payload streams onto one egress stream.
// Grants switch only at packet boundaries; the egress beat is registered and tagged with its source index.
module udp_stream_arbiter #(
  parameter int unsigned STREAM_DATA_WIDTH = 32,
  parameter int unsigned PORT_NUMBER       = 4,
  parameter int unsigned DEST_WIDTH        = (PORT_NUMBER > 1) ? $clog2(PORT_NUMBER) : 1
) (
  input  logic                                       clk_i,
  input  logic                                       s_rst_i,
  input  logic [PORT_NUMBER*STREAM_DATA_WIDTH-1:0]   s_axis_tdata_i,
  input  logic [PORT_NUMBER*STREAM_DATA_WIDTH/8-1:0] s_axis_tkeep_i,
  input  logic [PORT_NUMBER-1:0]                     s_axis_tvalid_i,
  input  logic [PORT_NUMBER-1:0]                     s_axis_tlast_i,
  output logic [PORT_NUMBER-1:0]                     s_axis_tready_o,
  output logic [STREAM_DATA_WIDTH-1:0]               m_axis_tdata_o,
  output logic [STREAM_DATA_WIDTH/8-1:0]             m_axis_tkeep_o,
  output logic                                       m_axis_tvalid_o,
  output logic                                       m_axis_tlast_o,
  output logic [DEST_WIDTH-1:0]                      m_axis_tdest_o,
  input  logic                                       m_axis_tready_i,
  output logic [PORT_NUMBER-1:0]                     grant_o,
  output logic                                       busy_o
);

  localparam int unsigned KEEP_WIDTH = STREAM_DATA_WIDTH / 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                         state, state_n;
  logic [DEST_WIDTH-1:0]          rr_ptr, rr_ptr_n;
  logic [DEST_WIDTH-1:0]          grant_idx, grant_idx_n;
  logic [PORT_NUMBER-1:0]         grant_n;
  logic [STREAM_DATA_WIDTH-1:0]   tdata_n, sel_data;
  logic [KEEP_WIDTH-1:0]          tkeep_n, sel_keep;
  logic                           tvalid_n, tlast_n, sel_valid, sel_last;
  logic [DEST_WIDTH-1:0]          tdest_n;
  logic                           out_free_c;
  logic                           found;
  logic [DEST_WIDTH-1:0]          pick;
  int unsigned                    probe;

  // First requester at or after rr_ptr, wrapping past the top port.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    probe = 0;
    for (int unsigned i = 0; i < PORT_NUMBER; i++) begin
      probe = 32'(rr_ptr) + i;
      if (probe >= PORT_NUMBER) probe = probe - PORT_NUMBER;
      if (!found && s_axis_tvalid_i[DEST_WIDTH'(probe)]) begin
        found = 1'b1;
        pick  = DEST_WIDTH'(probe);
      end
    end
  end

  // Slice of the currently granted port.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned k = 0; k < PORT_NUMBER; k++) begin
      if (DEST_WIDTH'(k) == grant_idx) begin
        sel_data  = s_axis_tdata_i[k*STREAM_DATA_WIDTH +: STREAM_DATA_WIDTH];
        sel_keep  = s_axis_tkeep_i[k*KEEP_WIDTH +: KEEP_WIDTH];
        sel_valid = s_axis_tvalid_i[k];
        sel_last  = s_axis_tlast_i[k];
      end
    end
  end

  assign out_free_c = !m_axis_tvalid_o || m_axis_tready_i;

  always_comb begin
    state_n         = state;
    rr_ptr_n        = rr_ptr;
    grant_idx_n     = grant_idx;
    grant_n         = grant_o;
    tdata_n         = m_axis_tdata_o;
    tkeep_n         = m_axis_tkeep_o;
    tlast_n         = m_axis_tlast_o;
    tdest_n         = m_axis_tdest_o;
    tvalid_n        = m_axis_tvalid_o;
    s_axis_tready_o = '0;

    if (m_axis_tvalid_o && m_axis_tready_i) tvalid_n = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          grant_idx_n = pick;
          grant_n     = PORT_NUMBER'(1) << pick;
          state_n     = GRANT;
        end
      end
      GRANT: begin
        s_axis_tready_o = out_free_c ? grant_o : '0;
        if (sel_valid && out_free_c) begin
          tdata_n  = sel_data;
          tkeep_n  = sel_keep;
          tlast_n  = sel_last;
          tdest_n  = grant_idx;
          tvalid_n = 1'b1;
          if (sel_last) begin
            state_n  = IDLE;
            grant_n  = '0;
            rr_ptr_n = (grant_idx == DEST_WIDTH'(PORT_NUMBER - 1)) ? '0 : grant_idx + DEST_WIDTH'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      grant_idx       <= '0;
      grant_o         <= '0;
      busy_o          <= 1'b0;
      m_axis_tdata_o  <= '0;
      m_axis_tkeep_o  <= '0;
      m_axis_tvalid_o <= 1'b0;
      m_axis_tlast_o  <= 1'b0;
      m_axis_tdest_o  <= '0;
    end else begin
      state           <= state_n;
      rr_ptr          <= rr_ptr_n;
      grant_idx       <= grant_idx_n;
      grant_o         <= grant_n;
      busy_o          <= (state_n == GRANT);
      m_axis_tdata_o  <= tdata_n;
      m_axis_tkeep_o  <= tkeep_n;
      m_axis_tvalid_o <= tvalid_n;
      m_axis_tlast_o  <= tlast_n;
      m_axis_tdest_o  <= tdest_n;
    end
  end

endmodule

// File: tb/tb_udp_stream_arbiter.sv
// Directed bench for udp_stream_arbiter: latency, round-robin order, stalls, single-beat packets, mid-packet reset.
module tb_udp_stream_arbiter;

  logic         clk = 1'b0;
  logic         s_rst;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic [3:0]   s_tvalid, s_tlast, s_tready;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep;
  logic         m_tvalid, m_tlast, m_tready;
  logic [1:0]   m_tdest;
  logic [3:0]   grant;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  udp_stream_arbiter #(.STREAM_DATA_WIDTH(32), .PORT_NUMBER(4)) dut (
    .clk_i(clk), .s_rst_i(s_rst),
    .s_axis_tdata_i(s_tdata), .s_axis_tkeep_i(s_tkeep), .s_axis_tvalid_i(s_tvalid),
    .s_axis_tlast_i(s_tlast), .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tkeep_o(m_tkeep), .m_axis_tvalid_o(m_tvalid),
    .m_axis_tlast_o(m_tlast), .m_axis_tdest_o(m_tdest), .m_axis_tready_i(m_tready),
    .grant_o(grant), .busy_o(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-port traffic plan for the cycle engine.
  int len[4], npkt[4], start[4], pkt_n[4], beat_n[4];
  bit rdy_pat[64];
  int exp_order[$];
  int gnt_log[$];

  typedef struct {
    int          dest;
    logic [31:0] data;
    logic        last;
    logic [3:0]  keep;
  } beat_t;
  beat_t obs[$];

  function automatic logic [31:0] beat_data(input int k, input int p, input int b);
    return 32'((k << 16) | (p << 8) | b);
  endfunction

  task automatic plan_clear();
    for (int k = 0; k < 4; k++) begin
      len[k] = 1; npkt[k] = 0; start[k] = 0;
    end
    for (int c = 0; c < 64; c++) rdy_pat[c] = 1'b1;
  endtask

  task automatic set_beat(input int k, input logic [31:0] d, input logic last);
    s_tdata[k*32 +: 32] = d;
    s_tkeep[k*4 +: 4]   = 4'hF;
    s_tlast[k]          = last;
  endtask

  task automatic apply_reset();
    s_rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; m_tready = 1'b1;
    repeat (2) @(negedge clk);
    s_rst = 1'b0;
  endtask

  // Runs ncyc cycles, driving the plan and logging egress beats and grants; starts on a negedge.
  task automatic run(input int ncyc);
    logic [3:0]  acc;
    logic [3:0]  prev_grant = '0;
    int          idle = 0;
    bit          hold_prev = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_last = 1'b0;
    obs.delete(); gnt_log.delete();
    for (int k = 0; k < 4; k++) begin pkt_n[k] = 0; beat_n[k] = 0; end
    for (int c = 0; c < ncyc; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (npkt[k] > 0 && c >= start[k]) begin
          s_tvalid[k]        = 1'b1;
          s_tdata[k*32 +: 32] = beat_data(k, pkt_n[k], beat_n[k]);
          s_tlast[k]         = (beat_n[k] == len[k] - 1);
          s_tkeep[k*4 +: 4]  = s_tlast[k] ? 4'h3 : 4'hF;
        end else begin
          s_tvalid[k] = 1'b0; s_tlast[k] = 1'b0;
          s_tdata[k*32 +: 32] = '0; s_tkeep[k*4 +: 4] = '0;
        end
      end
      m_tready = (c < 64) ? rdy_pat[c] : 1'b1;
      #1;
      if (hold_prev) begin
        check_eq("hold_valid", 32'(m_tvalid), 1);
        check_eq("hold_data", m_tdata, held_data);
        check_eq("hold_last", 32'(m_tlast), 32'(held_last));
      end
      if (m_tvalid && !m_tready) begin
        check_eq("stall_in_rdy", 32'(s_tready), 0);
        hold_prev = 1'b1; held_data = m_tdata; held_last = m_tlast;
      end else begin
        hold_prev = 1'b0;
      end
      if (m_tvalid && m_tready) obs.push_back('{dest: int'(m_tdest), data: m_tdata, last: m_tlast, keep: m_tkeep});
      if (grant != 0 && prev_grant == 0) begin
        check_eq("grant_onehot", 32'($onehot(grant)), 1);
        if (gnt_log.size() > 0) check_eq("idle_gap", 32'(idle), 1);
        for (int k = 0; k < 4; k++) if (grant[k]) gnt_log.push_back(k);
      end
      idle = (grant == 0) ? idle + 1 : 0;
      prev_grant = grant;
      acc = s_tvalid & s_tready;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (acc[k]) begin
          if (beat_n[k] == len[k] - 1) begin
            beat_n[k] = 0; pkt_n[k]++; npkt[k]--;
          end else begin
            beat_n[k]++;
          end
        end
      end
    end
    s_tvalid = '0; s_tlast = '0; m_tready = 1'b1;
  endtask

  // Compares grant order and egress beats against exp_order.
  task automatic check_stream();
    int pc[4];
    int idx = 0;
    int k;
    for (int i = 0; i < 4; i++) pc[i] = 0;
    check_eq("grant_count", 32'(gnt_log.size()), 32'(exp_order.size()));
    for (int i = 0; i < exp_order.size(); i++) begin
      k = exp_order[i];
      if (i < gnt_log.size()) check_eq("grant_order", 32'(gnt_log[i]), 32'(k));
      for (int b = 0; b < len[k]; b++) begin
        if (idx < obs.size()) begin
          check_eq("beat_dest", 32'(obs[idx].dest), 32'(k));
          check_eq("beat_data", obs[idx].data, beat_data(k, pc[k], b));
          check_eq("beat_last", 32'(obs[idx].last), 32'(b == len[k] - 1));
          check_eq("beat_keep", 32'(obs[idx].keep), (b == len[k] - 1) ? 32'h3 : 32'hF);
        end
        idx++;
      end
      pc[k]++;
    end
    check_eq("beat_count", 32'(obs.size()), 32'(idx));
  endtask

  initial begin
    s_rst = 1'b0; s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; m_tready = 1'b1;
    @(negedge clk);
    apply_reset();
    #1;
    check_eq("rst_valid", 32'(m_tvalid), 0);
    check_eq("rst_data", m_tdata, 0);
    check_eq("rst_keep", 32'(m_tkeep), 0);
    check_eq("rst_last", 32'(m_tlast), 0);
    check_eq("rst_dest", 32'(m_tdest), 0);
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_in_rdy", 32'(s_tready), 0);
    check_eq("rst_rr", 32'(dut.rr_ptr), 0);

    // Port 2, four beats 0xA0..0xA3, downstream always ready.
    @(negedge clk);
    s_tvalid = 4'b0100; set_beat(2, 32'hA0, 1'b0); m_tready = 1'b1;
    #1;
    check_eq("t1_idle_rdy", 32'(s_tready), 0);
    check_eq("t1_idle_grant", 32'(grant), 0);
    @(negedge clk);
    check_eq("t1_grant", 32'(grant), 32'h4);
    check_eq("t1_busy", 32'(busy), 1);
    check_eq("t1_in_rdy", 32'(s_tready), 32'h4);
    check_eq("t1_no_out", 32'(m_tvalid), 0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check_eq("t1_valid", 32'(m_tvalid), 1);
      check_eq("t1_data", m_tdata, 32'hA0 + 32'(b));
      check_eq("t1_dest", 32'(m_tdest), 2);
      check_eq("t1_last", 32'(m_tlast), 32'(b == 3));
      if (b < 3) set_beat(2, 32'hA1 + 32'(b), 1'(b == 2));
      else begin s_tvalid = '0; s_tlast = '0; end
    end
    #1;
    check_eq("t1_end_grant", 32'(grant), 0);
    check_eq("t1_end_busy", 32'(busy), 0);
    check_eq("t1_rr", 32'(dut.rr_ptr), 3);
    @(negedge clk);
    check_eq("t1_drained", 32'(m_tvalid), 0);

    // Port 3 granted first (rr_ptr=3); ports 1 and 2 queue up; wrap to 0 puts port 1 ahead of 2.
    plan_clear();
    len[3] = 3; npkt[3] = 1; start[3] = 0;
    len[1] = 2; npkt[1] = 1; start[1] = 1;
    len[2] = 2; npkt[2] = 1; start[2] = 2;
    exp_order = '{3, 1, 2};
    run(18);
    check_stream();

    // All four ports with 2-beat packets from reset: order 0,1,2,3,0.
    apply_reset();
    plan_clear();
    for (int k = 0; k < 4; k++) begin len[k] = 2; npkt[k] = 1; end
    npkt[0] = 2;
    exp_order = '{0, 1, 2, 3, 0};
    run(22);
    check_stream();

    // Downstream stall pattern 1,0,0,1 inside a 3-beat packet on port 1.
    plan_clear();
    len[1] = 3; npkt[1] = 1;
    rdy_pat[2] = 1'b1; rdy_pat[3] = 1'b0; rdy_pat[4] = 1'b0; rdy_pat[5] = 1'b1;
    exp_order = '{1};
    run(10);
    check_stream();

    // Two back-to-back single-beat packets on port 0.
    plan_clear();
    len[0] = 1; npkt[0] = 2;
    exp_order = '{0, 0};
    run(8);
    check_stream();

    // Reset after 2 of 5 beats on port 1.
    s_tvalid = 4'b0010; set_beat(1, 32'hB0, 1'b0); m_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_beat0", m_tdata, 32'hB0);
    set_beat(1, 32'hB1, 1'b0);
    @(negedge clk);
    check_eq("t6_beat1", m_tdata, 32'hB1);
    set_beat(1, 32'hB2, 1'b0);
    s_rst = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    #1;
    check_eq("t6_valid", 32'(m_tvalid), 0);
    check_eq("t6_data", m_tdata, 0);
    check_eq("t6_keep", 32'(m_tkeep), 0);
    check_eq("t6_last", 32'(m_tlast), 0);
    check_eq("t6_dest", 32'(m_tdest), 0);
    check_eq("t6_grant", 32'(grant), 0);
    check_eq("t6_busy", 32'(busy), 0);
    check_eq("t6_in_rdy", 32'(s_tready), 0);
    check_eq("t6_rr", 32'(dut.rr_ptr), 0);
    @(negedge clk);
    check_eq("t6_regrant", 32'(grant), 32'h2);
    check_eq("t6_no_fwd", 32'(m_tvalid), 0);
    s_tvalid = '0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_stream_arbiter.md
# udp_stream_arbiter

Round-robin AXI-Stream arbiter that merges up to PORT_NUMBER filtered UDP payload streams onto one shared egress stream. Grants change only at packet boundaries, so every output packet is one contiguous, unbroken input packet. It sits downstream of a bank of UDP filter instances, one per UDP port, and feeds the single payload consumer (DMA / FIFO). The output is registered, and every egress beat is tagged with its source index.

## Interface
Parameters:
- STREAM_DATA_WIDTH, 32, per-port and egress tdata width; multiple of 8.
- PORT_NUMBER, 4, number of requesting streams; legal range 1..16.
- DEST_WIDTH, $clog2(PORT_NUMBER) with a minimum of 1, width of the source index.

Ports:
- clk_i  input  1  sole clock.
- s_rst_i  input  1  reset, synchronous, active-high.
- s_axis_tdata_i  input  PORT_NUMBER*STREAM_DATA_WIDTH  packed input data; port k occupies slice k.
- s_axis_tkeep_i  input  PORT_NUMBER*STREAM_DATA_WIDTH/8  packed input byte enables.
- s_axis_tvalid_i  input  PORT_NUMBER  per-port valid.
- s_axis_tlast_i  input  PORT_NUMBER  per-port end of packet.
- s_axis_tready_o  output  PORT_NUMBER  per-port ready.
- m_axis_tdata_o  output  STREAM_DATA_WIDTH  egress data.
- m_axis_tkeep_o  output  STREAM_DATA_WIDTH/8  egress byte enables.
- m_axis_tvalid_o  output  1  egress valid.
- m_axis_tlast_o  output  1  egress end of packet.
- m_axis_tdest_o  output  DEST_WIDTH  index of the port that sourced the beat.
- m_axis_tready_i  input  1  egress ready.
- grant_o  output  PORT_NUMBER  one-hot current grant; all zero when idle.
- busy_o  output  1  high while a packet is in flight (state GRANT).

## Operation
- State machine has two states: IDLE and GRANT. The round-robin pointer rr_ptr (DEST_WIDTH bits) marks the highest-priority port.
- IDLE:
  - If any s_axis_tvalid_i bit is set, grant the first requester at or after rr_ptr, searching upward with wrap from PORT_NUMBER-1 to 0.
  - Register grant_idx and the one-hot grant, then go to GRANT.
  - All s_axis_tready_o bits are 0 in IDLE.
- GRANT:
  - s_axis_tready_o[grant_idx] = out_free, where out_free = !m_axis_tvalid_o || m_axis_tready_i.
  - All other tready bits are 0.
  - An accepted beat (valid & ready on the granted port) loads the output register: tdata, tkeep, tlast, and tdest = grant_idx. m_axis_tvalid_o is then set.
  - An accepted beat with tlast: go to IDLE, clear grant, set rr_ptr = grant_idx+1, wrapping PORT_NUMBER-1 to 0.
- Output register:
  - Holds its contents while m_axis_tvalid_o && !m_axis_tready_i.
  - Clears m_axis_tvalid_o when the held beat is taken and no new beat is loaded.
- A request that drops before being granted is not remembered.
- Requests on non-granted ports are ignored, never dropped: those ports see tready 0 until they are granted.
- With PORT_NUMBER = 1, the block degenerates to IDLE/GRANT sequencing on port 0 with m_axis_tdest_o = 0.

## Timing
- Reset: state IDLE, rr_ptr 0, grant_o 0, busy_o 0, all s_axis_tready_o 0. m_axis_tvalid_o, tlast, tdata, tkeep and tdest are all 0.
- Reset asserted mid-packet:
  - The in-flight packet is abandoned and the output register is cleared.
  - No tlast is emitted; the downstream side must tolerate the truncated packet.
  - Input ports are not drained.
- Arbitration latency: a request seen in IDLE at cycle t gives grant_o/busy_o at t+1. The first tready to the granted port is at t+1.
- Data latency: a beat accepted at cycle t appears on m_axis at t+1.
- Throughput inside a packet: 1 beat/cycle while m_axis_tready_i stays high.
- Packet turnaround: exactly one IDLE cycle between the last beat of one packet and the next grant.
- A single-beat packet (tvalid and tlast in the same cycle) is legal: GRANT lasts one cycle.
- A simultaneous final-beat accept and downstream stall is legal: the beat is registered and held, and the state still moves to IDLE.
- A bubble on the granted port (tvalid low) holds GRANT indefinitely. There is no timeout.

## Test plan
- Single port 2 request with a 4-beat packet, data 0xA0..0xA3, m_axis_tready_i held 1 -> grant_o=0100 one cycle after the request; the 4 beats appear on consecutive cycles, each one cycle after input accept; tdest=2 on every beat; tlast only on 0xA3; then idle; rr_ptr=3.
- All 4 ports request continuously with 2-beat packets -> grant order 0,1,2,3,0; exactly one idle cycle between packets; no beat interleaving.
- Port 3 is granted while port 1 requests, then port 1 and port 2 request together -> after port 3 finishes, rr_ptr wraps to 0 and port 1 is granted before port 2.
- m_axis_tready_i toggles 1,0,0,1 during a 3-beat packet -> output beat held stable across the stall; input tready low while the output register is full and not taken; no beat lost or duplicated.
- Single-beat packet on port 0 with tlast=1, followed by port 0 requesting again -> two grants separated by one IDLE cycle; m_axis_tlast_o=1 on both beats.
- Reset pulse after 2 of 5 beats -> next cycle all outputs are 0, state is IDLE, rr_ptr is 0; the remaining beats are not forwarded until a new grant.
